// File: rtl/taxi_pcie_us_cfg_mgmt_arb.sv
// Round-robin arbiter sharing one UltraScale PCIe cfg_mgmt port among PORTS requesters.
// One access in flight at a time; a hung access is aborted after TIMEOUT strobe cycles.
module taxi_pcie_us_cfg_mgmt_arb #(
  parameter  int PORTS    = 2,
  parameter  int TIMEOUT  = 256,
  localparam int CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS*10-1:0]   req_addr,
  input  logic [PORTS*8-1:0]    req_function_number,
  input  logic [PORTS-1:0]      req_write,
  input  logic [PORTS*32-1:0]   req_write_data,
  input  logic [PORTS*4-1:0]    req_byte_enable,
  input  logic [PORTS-1:0]      req_read,
  output logic [31:0]           req_read_data,
  output logic [PORTS-1:0]      req_done,
  output logic [PORTS-1:0]      req_err,
  output logic                  busy,
  output logic [CL_PORTS-1:0]   grant,
  output logic [9:0]            cfg_mgmt_addr,
  output logic [7:0]            cfg_mgmt_function_number,
  output logic                  cfg_mgmt_write,
  output logic [31:0]           cfg_mgmt_write_data,
  output logic [3:0]            cfg_mgmt_byte_enable,
  output logic                  cfg_mgmt_read,
  input  logic [31:0]           cfg_mgmt_read_data,
  input  logic                  cfg_mgmt_read_write_done
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PORTS-1:0] PORT_ONE = PORTS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CL_PORTS-1:0] last_q;
  logic [CL_PORTS-1:0] grant_q;
  logic                busy_q;
  logic [PORTS-1:0]    req_done_q;
  logic [PORTS-1:0]    req_err_q;
  logic [31:0]         rdata_q;
  logic [9:0]          cfg_addr_q;
  logic [7:0]          cfg_fn_q;
  logic                cfg_write_q;
  logic                cfg_read_q;
  logic [31:0]         cfg_wdata_q;
  logic [3:0]          cfg_be_q;

  logic [PORTS-1:0]    pending_d;
  logic [CL_PORTS-1:0] pick_d;
  logic                found_d;
  logic                hit_d;
  int                  cand_d;
  int                  sel_d;
  logic                expire_d;

  // Round-robin search for the first pending port after the last one granted
  always_comb begin
    pending_d = req_read | req_write;
    pick_d    = last_q;
    found_d   = 1'b0;
    hit_d     = 1'b0;
    cand_d    = 0;
    for (int i = 0; i < PORTS; i++) begin
      cand_d  = int'(last_q) + 1 + i;
      cand_d  = (cand_d >= PORTS) ? (cand_d - PORTS) : cand_d;
      hit_d   = !found_d && pending_d[cand_d];
      pick_d  = hit_d ? CL_PORTS'(cand_d) : pick_d;
      found_d = found_d | hit_d;
    end
    sel_d    = int'(pick_d);
    expire_d = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Arbitration / access FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= CL_PORTS'(PORTS - 1);
      grant_q     <= '0;
      busy_q      <= 1'b0;
      req_done_q  <= '0;
      req_err_q   <= '0;
      rdata_q     <= 32'h0000_0000;
      cfg_addr_q  <= 10'h000;
      cfg_fn_q    <= 8'h00;
      cfg_write_q <= 1'b0;
      cfg_read_q  <= 1'b0;
      cfg_wdata_q <= 32'h0000_0000;
      cfg_be_q    <= 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_done_q <= '0;
          req_err_q  <= '0;
          cnt_q      <= '0;
          if (found_d) begin
            grant_q     <= pick_d;
            last_q      <= pick_d;
            busy_q      <= 1'b1;
            cfg_addr_q  <= req_addr[sel_d*10 +: 10];
            cfg_fn_q    <= req_function_number[sel_d*8 +: 8];
            cfg_wdata_q <= req_write_data[sel_d*32 +: 32];
            cfg_be_q    <= req_byte_enable[sel_d*4 +: 4];
            // Write takes precedence when both read and write are raised
            cfg_write_q <= req_write[sel_d];
            cfg_read_q  <= ~req_write[sel_d];
            state_q     <= ST_ACTIVE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (cfg_mgmt_read_write_done) begin
            cfg_write_q <= 1'b0;
            cfg_read_q  <= 1'b0;
            rdata_q     <= cfg_write_q ? 32'h0000_0000 : cfg_mgmt_read_data;
            req_done_q  <= PORT_ONE << grant_q;
            req_err_q   <= '0;
            state_q     <= ST_DONE;
          end else if (expire_d) begin
            cfg_write_q <= 1'b0;
            cfg_read_q  <= 1'b0;
            rdata_q     <= 32'hFFFF_FFFF;
            req_done_q  <= PORT_ONE << grant_q;
            req_err_q   <= PORT_ONE << grant_q;
            state_q     <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_ACTIVE;
          end
        end
        ST_DONE: begin
          // No arbitration here, so the finishing port's dropped request is never re-granted
          req_done_q <= '0;
          req_err_q  <= '0;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          cfg_write_q <= 1'b0;
          cfg_read_q  <= 1'b0;
          req_done_q  <= '0;
          req_err_q   <= '0;
          cnt_q       <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_read_data            = rdata_q;
  assign req_done                 = req_done_q;
  assign req_err                  = req_err_q;
  assign busy                     = busy_q;
  assign grant                    = grant_q;
  assign cfg_mgmt_addr            = cfg_addr_q;
  assign cfg_mgmt_function_number = cfg_fn_q;
  assign cfg_mgmt_write           = cfg_write_q;
  assign cfg_mgmt_write_data      = cfg_wdata_q;
  assign cfg_mgmt_byte_enable     = cfg_be_q;
  assign cfg_mgmt_read            = cfg_read_q;

endmodule

// File: tb/tb_taxi_pcie_us_cfg_mgmt_arb.sv
// Bench for taxi_pcie_us_cfg_mgmt_arb: transaction-level model of requesters, arbiter and core.
// Directed scenarios followed by randomized traffic and a mid-access reset.
module tb_taxi_pcie_us_cfg_mgmt_arb;
  localparam int PORTS   = 3;
  localparam int TIMEOUT = 16;
  localparam int CLP     = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PORTS*10-1:0]   req_addr;
  logic [PORTS*8-1:0]    req_function_number;
  logic [PORTS-1:0]      req_write;
  logic [PORTS*32-1:0]   req_write_data;
  logic [PORTS*4-1:0]    req_byte_enable;
  logic [PORTS-1:0]      req_read;
  logic [31:0]           req_read_data;
  logic [PORTS-1:0]      req_done;
  logic [PORTS-1:0]      req_err;
  logic                  busy;
  logic [CLP-1:0]        grant;
  logic [9:0]            cfg_mgmt_addr;
  logic [7:0]            cfg_mgmt_function_number;
  logic                  cfg_mgmt_write;
  logic [31:0]           cfg_mgmt_write_data;
  logic [3:0]            cfg_mgmt_byte_enable;
  logic                  cfg_mgmt_read;
  logic [31:0]           cfg_mgmt_read_data;
  logic                  cfg_mgmt_read_write_done;

  taxi_pcie_us_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_function_number(req_function_number),
    .req_write(req_write), .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable), .req_read(req_read),
    .req_read_data(req_read_data), .req_done(req_done), .req_err(req_err),
    .busy(busy), .grant(grant),
    .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_write_data(cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable), .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_read_data(cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done)
  );

  always #5 clk = ~clk;

  // requester state
  logic        r_rd [PORTS];
  logic        r_wr [PORTS];
  logic [9:0]  r_addr [PORTS];
  logic [7:0]  r_fn [PORTS];
  logic [31:0] r_wd [PORTS];
  logic [3:0]  r_be [PORTS];
  logic [PORTS-1:0] auto_mask;

  // model state
  int          n_total = 0;
  int          n_bad = 0;
  int          m_phase;   // 0 idle, 1 access outstanding, 2 completion pulse seen
  int          m_last;
  bit          m_arb;
  int          m_port;
  int          m_cyc;
  int          m_lat;
  int          m_strb;
  logic        s_wr;
  logic [9:0]  s_addr;
  logic [7:0]  s_fn;
  logic [31:0] s_wd;
  logic [3:0]  s_be;
  logic [31:0] core_data;
  bit          rand_mode;
  int          fixed_lat;
  logic [31:0] fixed_data;
  int          stray_cnt;
  int          grants[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < PORTS; p++) begin
      req_addr[p*10 +: 10]            = r_addr[p];
      req_function_number[p*8 +: 8]   = r_fn[p];
      req_write_data[p*32 +: 32]      = r_wd[p];
      req_byte_enable[p*4 +: 4]       = r_be[p];
      req_read[p]                     = r_rd[p];
      req_write[p]                    = r_wr[p];
    end
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < PORTS; p++) begin
      r_rd[p] = 1'b0; r_wr[p] = 1'b0;
      r_addr[p] = 10'h000; r_fn[p] = 8'h00; r_wd[p] = 32'h0; r_be[p] = 4'h0;
    end
    auto_mask = '0;
  endtask

  // Predict the next grant from what the requesters are presenting right now
  task automatic model_arb();
    int p;
    m_arb = 1'b0;
    if (m_phase == 0) begin
      for (int k = 1; k <= PORTS; k++) begin
        p = (m_last + k) % PORTS;
        if (!m_arb && (r_rd[p] || r_wr[p])) begin
          m_arb  = 1'b1;
          m_port = p;
          s_wr   = r_wr[p];
          s_addr = r_addr[p]; s_fn = r_fn[p]; s_wd = r_wd[p]; s_be = r_be[p];
        end
      end
    end
  endtask

  task automatic idle_chk();
    check_val("idle_strobe", {30'd0, cfg_mgmt_write, cfg_mgmt_read}, 32'd0);
    check_val("idle_done", {29'd0, req_done}, 32'd0);
    check_val("idle_err", {29'd0, req_err}, 32'd0);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic step();
    logic [31:0] exp_rd;
    logic [31:0] onehot;
    logic [31:0] rnd;
    int kind;
    @(negedge clk);
    onehot = 32'd1 << m_port;
    case (m_phase)
      0: begin
        if (m_arb) begin
          check_val("strobe_rise", {30'd0, cfg_mgmt_write, cfg_mgmt_read}, s_wr ? 32'd2 : 32'd1);
          check_val("grant", {30'd0, grant}, m_port);
          check_val("addr", {22'd0, cfg_mgmt_addr}, {22'd0, s_addr});
          check_val("fn", {24'd0, cfg_mgmt_function_number}, {24'd0, s_fn});
          check_val("wdata", cfg_mgmt_write_data, s_wd);
          check_val("be", {28'd0, cfg_mgmt_byte_enable}, {28'd0, s_be});
          check_val("busy_on", {31'd0, busy}, 32'd1);
          grants.push_back(m_port);
          m_last    = m_port;
          m_phase   = 1;
          m_cyc     = 1;
          m_lat     = rand_mode ? int'($urandom_range(1, 20)) : fixed_lat;
          core_data = rand_mode ? $urandom : fixed_data;
          m_strb    = (m_lat <= TIMEOUT) ? m_lat : TIMEOUT;
        end else begin
          idle_chk();
        end
      end
      1: begin
        m_cyc++;
        if (m_cyc <= m_strb) begin
          check_val("strobe_hold", {30'd0, cfg_mgmt_write, cfg_mgmt_read}, s_wr ? 32'd2 : 32'd1);
          check_val("addr_hold", {22'd0, cfg_mgmt_addr}, {22'd0, s_addr});
          check_val("early_done", {29'd0, req_done}, 32'd0);
        end else begin
          exp_rd = (m_lat > TIMEOUT) ? 32'hFFFF_FFFF : (s_wr ? 32'h0 : core_data);
          check_val("strobe_drop", {30'd0, cfg_mgmt_write, cfg_mgmt_read}, 32'd0);
          check_val("done", {29'd0, req_done}, onehot);
          check_val("err", {29'd0, req_err}, (m_lat > TIMEOUT) ? onehot : 32'd0);
          check_val("rdata", req_read_data, exp_rd);
          m_phase = 2;
        end
      end
      default: begin
        idle_chk();
        m_phase = 0;
      end
    endcase
    // core side
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data = $urandom;
    if (m_phase == 1 && m_cyc == m_lat) begin
      cfg_mgmt_read_write_done = 1'b1;
      cfg_mgmt_read_data = core_data;
    end else if (m_phase != 1 && (stray_cnt == 0 || (rand_mode && $urandom_range(0, 7) == 0))) begin
      cfg_mgmt_read_write_done = 1'b1;
    end
    if (stray_cnt >= 0) stray_cnt--;
    // requesters: raise new work, then drop on completion
    for (int p = 0; p < PORTS; p++) begin
      if (!(r_rd[p] || r_wr[p])) begin
        if (auto_mask[p]) begin
          r_rd[p] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          rnd = $urandom; r_addr[p] = rnd[9:0]; r_fn[p] = rnd[17:10]; r_be[p] = rnd[21:18];
          r_wd[p] = $urandom;
          kind = int'($urandom_range(0, 2));
          r_rd[p] = (kind != 1);
          r_wr[p] = (kind != 0);
        end
      end
      if (req_done[p]) begin
        r_rd[p] = 1'b0; r_wr[p] = 1'b0;
      end
    end
    drive_inputs();
    model_arb();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = PORTS - 1; m_arb = 1'b0; m_port = 0; m_cyc = 0;
    m_lat = 0; m_strb = 0; stray_cnt = -1;
  endtask

  task automatic all_zero_chk(input string tag);
    check_val({tag, "_strobe"}, {30'd0, cfg_mgmt_write, cfg_mgmt_read}, 32'd0);
    check_val({tag, "_addr"}, {22'd0, cfg_mgmt_addr}, 32'd0);
    check_val({tag, "_fn"}, {24'd0, cfg_mgmt_function_number}, 32'd0);
    check_val({tag, "_wdata"}, cfg_mgmt_write_data, 32'd0);
    check_val({tag, "_be"}, {28'd0, cfg_mgmt_byte_enable}, 32'd0);
    check_val({tag, "_done"}, {29'd0, req_done}, 32'd0);
    check_val({tag, "_err"}, {29'd0, req_err}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check_val({tag, "_rdata"}, req_read_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data = 32'h0;
    rand_mode = 1'b0; fixed_lat = 3; fixed_data = 32'h0;
    clear_reqs();
    drive_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    all_zero_chk("reset");
    rst_n = 1'b1;

    // single read, port 0
    fixed_lat = 3; fixed_data = 32'h0000_2810;
    r_rd[0] = 1'b1; r_addr[0] = 10'h032; r_fn[0] = 8'h00; r_be[0] = 4'hF;
    drive_inputs(); model_arb();
    steps(10);

    // single write, port 1
    fixed_lat = 2; fixed_data = 32'h1234_5678;
    r_wr[1] = 1'b1; r_addr[1] = 10'h155; r_fn[1] = 8'h03; r_wd[1] = 32'hDEAD_BEEF; r_be[1] = 4'hF;
    drive_inputs(); model_arb();
    steps(10);

    // ports 0 and 1 requesting continuously
    grants.delete();
    fixed_lat = 2; fixed_data = 32'h0BAD_F00D;
    auto_mask = 3'b011;
    for (int g = 0; g < 200 && grants.size() < 6; g++) step();
    auto_mask = '0;
    check_val("alt_count", (grants.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check_val("alt_grant", grants[i], i % 2);
    steps(20);

    // timeout with a late completion afterwards
    fixed_lat = 1000; fixed_data = 32'h5555_AAAA;
    r_rd[0] = 1'b1; r_addr[0] = 10'h3FF; r_fn[0] = 8'h07; r_be[0] = 4'h3;
    drive_inputs(); model_arb();
    steps(19);
    stray_cnt = 3;
    steps(8);
    check_val("late_rdata", req_read_data, 32'hFFFF_FFFF);

    // completion on the expiry cycle
    fixed_lat = TIMEOUT; fixed_data = 32'hA5A5_1234;
    r_rd[1] = 1'b1; r_addr[1] = 10'h0F0; r_fn[1] = 8'h01; r_be[1] = 4'hC;
    drive_inputs(); model_arb();
    steps(22);

    // randomized traffic, then drain
    rand_mode = 1'b1;
    steps(800);
    rand_mode = 1'b0; fixed_lat = 2; fixed_data = 32'h7777_0000;
    steps(60);

    // reset in the middle of an access
    fixed_lat = 1000;
    r_wr[2] = 1'b1; r_addr[2] = 10'h2AA; r_fn[2] = 8'h55; r_wd[2] = 32'hCAFE_0001; r_be[2] = 4'h9;
    drive_inputs(); model_arb();
    steps(4);
    check_val("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 all_zero_chk("midrst");
    clear_reqs(); drive_inputs();
    cfg_mgmt_read_write_done = 1'b0;
    repeat (2) @(negedge clk);
    all_zero_chk("rst_hold");
    rst_n = 1'b1;
    model_reset();
    grants.delete();
    fixed_lat = 1; fixed_data = 32'h0000_00C3;
    for (int p = 0; p < PORTS; p++) begin
      r_rd[p] = 1'b1; r_addr[p] = 10'(p + 1); r_be[p] = 4'hF;
    end
    drive_inputs(); model_arb();
    steps(20);
    check_val("post_rst_count", grants.size(), 32'd3);
    if (grants.size() > 0) check_val("post_rst_first", grants[0], 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
